// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared types and constants for the IFU fetch sequencer.
// The reset PC is also used by the IFU PC register.
package ifu_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_EXEC  = 3'd4,
        S_HALT  = 3'd5
    } state_e;

    typedef logic [1:0] fcode_t;

    localparam fcode_t      FC_NONE     = 2'b00;
    localparam fcode_t      FC_MISALIGN = 2'b01;
    localparam fcode_t      FC_BUSERR   = 2'b10;
    localparam fcode_t      FC_TIMEOUT  = 2'b11;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [31:0] RESET_PC    = 32'h8000_0000;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_timeout_cnt.sv
// Response-wait counter: cleared on the AR handshake, counts S_WAIT cycles.
// expired_o flags the last permitted wait cycle (TIMEOUT cycles spent waiting).
module fetch_timeout_cnt #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires while the counter is about to reach TIMEOUT, so S_WAIT lasts at most TIMEOUT cycles.
    assign expired_o = en_i && (cnt_q == TIMEOUT - 8'd1);

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Multi-cycle fetch sequencer: AR/R read, IDU valid/ready handoff, PC write on commit.
// Best case 4 cycles per instruction; every stage stalls on its handshake, faults park the core.
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_wen_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    input  logic              commit_i,
    input  logic              halt_i,
    output logic              fault_o,
    output logic [1:0]        fault_code_o,
    output logic              busy_o
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              fault_q, fault_d;
    fcode_t            code_q, code_d;
    logic              ar_hs;
    logic              tmo_expired;

    assign ar_hs = (state_q == S_REQ) && !pc_misaligned(pc_i[1:0]) && arready_i;

    fetch_timeout_cnt #(
        .TIMEOUT (8'(TIMEOUT))
    ) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (ar_hs),
        .en_i      (state_q == S_WAIT),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fault_d      = fault_q;
        code_d       = code_q;
        arvalid_o    = 1'b0;
        rready_o     = 1'b0;
        inst_valid_o = 1'b0;
        pc_wen_o     = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (pc_misaligned(pc_i[1:0])) begin
                    fault_d = 1'b1;
                    code_d  = FC_MISALIGN;
                    state_d = S_HALT;
                end else begin
                    arvalid_o = 1'b1;
                    if (arready_i) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                rready_o = 1'b1;
                // A response in the expiry cycle still wins over the timeout.
                if (rvalid_i) begin
                    if (rresp_i == RESP_OKAY) begin
                        inst_d    = rdata_i;
                        inst_pc_d = pc_i;
                        state_d   = S_ISSUE;
                    end else begin
                        fault_d = 1'b1;
                        code_d  = FC_BUSERR;
                        state_d = S_HALT;
                    end
                end else if (tmo_expired) begin
                    fault_d = 1'b1;
                    code_d  = FC_TIMEOUT;
                    state_d = S_HALT;
                end
            end
            S_ISSUE: begin
                inst_valid_o = 1'b1;
                if (inst_ready_i) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (commit_i) begin
                    pc_wen_o = 1'b1;
                    state_d  = halt_i ? S_HALT : S_REQ;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fault_q   <= 1'b0;
            code_q    <= FC_NONE;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
        end
    end

    assign araddr_o     = arvalid_o ? pc_i : '0;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign fault_o      = fault_q;
    assign fault_code_o = code_q;
    assign busy_o       = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: scenario table, random fetch stream against a latency/PC model,
// and hand sequences for timeout, response-vs-timeout priority and reset mid-transaction.
module tb_ifu_fetch_ctrl;
    import ifu_fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_wen_o;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        commit_i;
    logic        halt_i;
    logic        fault_o;
    logic [1:0]  fault_code_o;
    logic        busy_o;

    always #5 clk = ~clk;

    ifu_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_wen_o     (pc_wen_o),
        .araddr_o     (araddr_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .rdata_i      (rdata_i),
        .rresp_i      (rresp_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .commit_i     (commit_i),
        .halt_i       (halt_i),
        .fault_o      (fault_o),
        .fault_code_o (fault_code_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [1:0]  resp;
        int          da;
        int          dr;
        int          dv;
        int          dc;
        logic        halt;
        logic [1:0]  exp_code;
        int          exp_lat;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int n_cyc = 0;
    int n_wen = 0;

    always @(negedge clk) if (pc_wen_o) n_wen++;

    function automatic logic [7:0] ctl();
        return {pc_wen_o, arvalid_o, rready_o, inst_valid_o, fault_o, fault_code_o, busy_o};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        n_cyc++;
    endtask

    // Leaves the DUT in its first S_REQ cycle, one time unit after the edge.
    task automatic do_reset();
        rst = 1'b0; arready_i = 1'b0; rvalid_i = 1'b0; rresp_i = 2'b00; rdata_i = 32'h0;
        inst_ready_i = 1'b0; commit_i = 1'b0; halt_i = 1'b0; pc_i = RESET_PC;
        cyc();
        #1;
        chk("reset_ctl", 64'(ctl()), 64'h0);
        chk("reset_araddr", 64'(araddr_o), 64'h0);
        chk("reset_inst", 64'(inst_o), 64'h0);
        chk("reset_inst_pc", 64'(inst_pc_o), 64'h0);
        rst = 1'b1;
        cyc();
    endtask

    task automatic end_halt(input vec_t v);
        logic [7:0] exp;
        exp = {4'b0000, v.exp_code != FC_NONE, v.exp_code, 1'b0};
        commit_i = 1'b1;
        #1;
        chk("halt_ctl", 64'(ctl()), 64'(exp));
        cyc();
        #1;
        chk("halt_sticky", 64'(ctl()), 64'(exp));
        commit_i = 1'b0;
    endtask

    task automatic run_fetch(input vec_t v);
        int t0;
        t0 = n_cyc;
        pc_i = v.pc;
        if (v.pc[1:0] != 2'b00) begin
            arready_i = 1'b1;
            #1;
            chk("misalign_arvalid", 64'(arvalid_o), 64'h0);
            cyc();
            arready_i = 1'b0;
            end_halt(v);
            return;
        end
        for (int j = 0; j <= v.da; j++) begin
            if (j > 0) cyc();
            arready_i = (j == v.da);
            halt_i    = 1'b1;
            #1;
            chk("ar_valid", 64'(arvalid_o), 64'h1);
            chk("ar_addr", 64'(araddr_o), 64'(v.pc));
        end
        for (int j = 0; j <= v.dr; j++) begin
            cyc();
            arready_i = 1'b0;
            halt_i    = 1'b0;
            rvalid_i  = (j == v.dr);
            rdata_i   = (j == v.dr) ? v.data : $urandom;
            rresp_i   = (j == v.dr) ? v.resp : RESP_OKAY;
            #1;
            chk("wait_hs", 64'({rready_o, arvalid_o, inst_valid_o}), 64'h4);
        end
        for (int j = 0; j <= v.dv; j++) begin
            cyc();
            rvalid_i     = 1'b0;
            rdata_i      = $urandom;
            if (j == 0 && v.resp != RESP_OKAY) begin
                end_halt(v);
                return;
            end
            inst_ready_i = (j == v.dv);
            commit_i     = (j == 0);
            #1;
            chk("issue_valid", 64'(inst_valid_o), 64'h1);
            chk("issue_inst", 64'(inst_o), 64'(v.data));
            chk("issue_inst_pc", 64'(inst_pc_o), 64'(v.pc));
            chk("commit_outside_exec", 64'(pc_wen_o), 64'h0);
        end
        for (int j = 0; j <= v.dc; j++) begin
            cyc();
            inst_ready_i = 1'b0;
            commit_i     = (j == v.dc);
            halt_i       = (j == v.dc) && v.halt;
            #1;
            chk("exec_wen", 64'(pc_wen_o), 64'(j == v.dc));
            chk("exec_valid", 64'(inst_valid_o), 64'h0);
        end
        cyc();
        commit_i = 1'b0;
        halt_i   = 1'b0;
        if (v.halt) begin
            end_halt(v);
            return;
        end
        chk("latency", 64'(n_cyc - t0), 64'(v.exp_lat));
    endtask

    // Waits in S_WAIT with no response; optionally returns data in the final permitted cycle.
    task automatic wait_seq(input logic late_rvalid);
        int n;
        n = 0;
        do_reset();
        arready_i = 1'b1;
        cyc();
        arready_i = 1'b0;
        for (int g = 0; g < 400; g++) begin
            rvalid_i = late_rvalid && (n == 254);
            rdata_i  = 32'hCAFE_0001;
            rresp_i  = RESP_OKAY;
            #1;
            if (!rready_o) break;
            n++;
            cyc();
            rvalid_i = 1'b0;
        end
        chk(late_rvalid ? "late_wait_cycles" : "tmo_wait_cycles", 64'(n), 64'd255);
        if (late_rvalid) begin
            chk("late_ctl", 64'(ctl()), 64'h11);
            chk("late_inst", 64'(inst_o), 64'hCAFE_0001);
        end else begin
            chk("tmo_ctl", 64'(ctl()), 64'h0E);
        end
    endtask

    vec_t tbl[7];

    initial begin
        vec_t v;
        logic [31:0] pcm;
        int base;

        tbl[0] = '{32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 0, 0, 1'b0, FC_NONE, 4};
        tbl[1] = '{32'h8000_0004, 32'hDEAD_BEEF, 2'b00, 5, 0, 3, 1, 1'b0, FC_NONE, 13};
        tbl[2] = '{32'h8000_0002, 32'h1111_1111, 2'b00, 0, 0, 0, 0, 1'b0, FC_MISALIGN, 0};
        tbl[3] = '{32'h8000_0008, 32'h2222_2222, 2'b10, 1, 2, 0, 0, 1'b0, FC_BUSERR, 0};
        tbl[4] = '{32'h8000_000C, 32'h0010_0073, 2'b00, 0, 1, 1, 2, 1'b1, FC_NONE, 0};
        tbl[5] = '{32'h8000_0010, 32'h3333_3333, 2'b01, 0, 0, 0, 0, 1'b0, FC_BUSERR, 0};
        tbl[6] = '{32'h8000_0003, 32'h4444_4444, 2'b00, 0, 0, 0, 0, 1'b0, FC_MISALIGN, 0};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_fetch(tbl[i]);
        end

        // Random stream: the bench plays the PC register, loading a new PC on each pc_wen_o.
        do_reset();
        pcm  = RESET_PC;
        base = n_wen;
        for (int k = 0; k < 40; k++) begin
            v.pc       = pcm;
            v.data     = $urandom;
            v.resp     = RESP_OKAY;
            v.da       = $urandom_range(0, 3);
            v.dr       = $urandom_range(0, 3);
            v.dv       = $urandom_range(0, 3);
            v.dc       = $urandom_range(0, 3);
            v.halt     = 1'b0;
            v.exp_code = FC_NONE;
            v.exp_lat  = 4 + v.da + v.dr + v.dv + v.dc;
            run_fetch(v);
            pcm = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : pcm + 32'd4;
        end
        chk("wen_count", 64'(n_wen - base), 64'd40);

        wait_seq(1'b0);
        wait_seq(1'b1);

        // Reset in S_WAIT with a response in the same cycle: the beat is dropped.
        do_reset();
        run_fetch(tbl[0]);
        pc_i      = 32'h8000_0004;
        arready_i = 1'b1;
        cyc();
        arready_i = 1'b0;
        rst       = 1'b0;
        rvalid_i  = 1'b1;
        rdata_i   = 32'hFFFF_FFFF;
        cyc();
        rvalid_i  = 1'b0;
        #1;
        chk("rst_wait_ctl", 64'(ctl()), 64'h0);
        chk("rst_wait_inst", 64'(inst_o), 64'h0);
        chk("rst_wait_inst_pc", 64'(inst_pc_o), 64'h0);
        chk("rst_wait_araddr", 64'(araddr_o), 64'h0);
        rst = 1'b1;
        cyc();
        #1;
        chk("rst_wait_req", 64'({arvalid_o, busy_o}), 64'h3);
        chk("rst_wait_req_addr", 64'(araddr_o), 64'h8000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
Multi-cycle fetch sequencer for the IFU/PC register.
- Issues one instruction read per instruction over an AXI4-Lite-style AR/R channel.
- Latches the returned word and hands it to the IDU with valid/ready.
- Waits for the committing stage to retire the instruction, then pulses the PC register write-enable (the IFU's ready input) so the next PC (pc+4 / branch / jump) is loaded.
- Detects misaligned PCs, bus errors, response timeouts and halt, and parks the core.

Parameters:
- ADDR_W, 32, PC/address width
- DATA_W, 32, instruction width
- TIMEOUT, 255, maximum cycles spent in S_WAIT before a timeout fault; the counter is 8 bits wide

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset, sampled on the rising edge of clk)
- pc_i  in  ADDR_W  current PC, taken from the IFU PC register output
- pc_wen_o  out  1  one-cycle pulse that loads the next PC into the IFU PC register
- araddr_o  out  ADDR_W  read address; equals pc_i while arvalid_o is high
- arvalid_o  out  1  read-address valid
- arready_i  in  1  read-address ready
- rdata_i  in  DATA_W  read data
- rresp_i  in  2  read response; 2'b00 = OKAY, any other value = error
- rvalid_i  in  1  read-data valid
- rready_o  out  1  read-data ready
- inst_o  out  DATA_W  latched instruction to the IDU
- inst_pc_o  out  ADDR_W  PC of inst_o
- inst_valid_o  out  1  instruction valid to the IDU
- inst_ready_i  in  1  IDU accepts the instruction
- commit_i  in  1  one-cycle pulse: current instruction retired, next PC already selected by the IFU mux
- halt_i  in  1  ebreak/halt request from the EXU
- fault_o  out  1  sticky fetch fault
- fault_code_o  out  2  fault cause: 01 misaligned, 10 bus error, 11 timeout, 00 none
- busy_o  out  1  high in every state except S_IDLE and S_HALT

Behaviour:
- Reset (rst=0 at a clock edge):
  - state <= S_IDLE; timeout counter, inst_o, inst_pc_o, fault_o and fault_code_o <= 0.
  - All outputs are 0 in the cycle after reset.
  - Reset wins over every other event in every state, including mid-transaction; an outstanding R beat after reset is dropped, because rready_o=0 in S_IDLE.
- States: S_IDLE, S_REQ, S_WAIT, S_ISSUE, S_EXEC, S_HALT. All outputs are decoded from registered state and registers.
- S_IDLE: go to S_REQ on the next edge, unconditionally.
- S_REQ:
  - If pc_i[1:0] != 0: set fault (code 01), go to S_HALT, and do not assert arvalid_o.
  - Otherwise arvalid_o=1 and araddr_o=pc_i. On arready_i=1: clear the timeout counter and go to S_WAIT.
  - arvalid_o stays high until the handshake completes; araddr_o is stable meanwhile.
- S_WAIT:
  - rready_o=1; the counter increments each cycle.
  - On rvalid_i with rresp_i=00: inst_o <= rdata_i, inst_pc_o <= pc_i, go to S_ISSUE.
  - On rvalid_i with rresp_i != 00: fault (code 10), go to S_HALT.
  - If the counter reaches TIMEOUT with no rvalid_i: fault (code 11), go to S_HALT. rvalid_i in that same cycle takes priority over the timeout.
- S_ISSUE:
  - inst_valid_o=1; inst_o and inst_pc_o are held stable.
  - On inst_ready_i=1 go to S_EXEC. inst_valid_o does not drop without a handshake.
- S_EXEC:
  - Wait for commit_i. On commit_i=1: pc_wen_o=1 for exactly that cycle (combinational on commit_i in S_EXEC), go to S_REQ.
  - The next fetch therefore sees the updated PC, with a 1-cycle gap between commit and arvalid_o.
  - If halt_i and commit_i are both 1: the PC is still written and the next state is S_HALT.
  - halt_i alone is ignored outside S_EXEC.
- S_HALT: all handshake outputs 0 and busy_o=0; exit only by reset. fault_o/fault_code_o keep their value (00 for a clean halt).
- commit_i outside S_EXEC is ignored: no pc_wen_o pulse.
- Best-case latency per instruction: S_REQ 1, S_WAIT 1, S_ISSUE 1, S_EXEC 1 = 4 cycles.

Decomposition:
- Shared package holds: state enum (3-bit, S_IDLE=0 … S_HALT=5), fault code constants (FC_NONE, FC_MISALIGN, FC_BUSERR, FC_TIMEOUT), RESP_OKAY=2'b00, and the reset PC constant 32'h8000_0000 shared with the IFU.
- One sub-module, fetch_timeout_cnt: 8-bit counter with clear, enable and expired output.
- FSM and datapath registers stay in this module.

Test Plan:
1. Release reset with pc_i=32'h8000_0000, memory returns 32'h0000_0413 with 0-cycle arready and 1-cycle rvalid, IDU ready, commit one cycle later -> araddr_o=32'h8000_0000, inst_o=32'h0000_0413, inst_pc_o=32'h8000_0000, exactly one pc_wen_o pulse, 4 cycles per instruction.
2. arready_i held low for 5 cycles, inst_ready_i low for 3 cycles -> arvalid_o/araddr_o stable for 6 cycles; inst_valid_o/inst_o stable until the handshake; no pc_wen_o.
3. pc_i=32'h8000_0002 in S_REQ -> arvalid_o never asserted; fault_o=1, fault_code_o=01, state S_HALT.
4. rvalid_i with rresp_i=2'b10 -> fault_code_o=10, inst_valid_o stays 0. Separately, no rvalid_i for 255 cycles -> fault_code_o=11.
5. halt_i=1 together with commit_i=1 -> one pc_wen_o pulse, then S_HALT with busy_o=0 and fault_code_o=00; a later commit_i produces no pulse.
6. rst=0 asserted while in S_WAIT, with rvalid_i arriving in the same cycle -> next cycle all outputs 0, inst_o=0, state S_IDLE, then S_REQ.
